// File: rtl/real_moving_avg_pkg.sv
// Shared limits and the elaboration-time alignment helper for the moving-average filter.
package real_moving_avg_pkg;

    localparam int LOG2_N_MIN  = 1;
    localparam int LOG2_N_MAX  = 8;
    localparam int SHIFT_LIMIT = 31;

    // The mean carries exponent exp_in - log2_n; a positive result means shift left into the output grid.
    function automatic int calc_shift(input int exp_in, input int exp_out, input int log2_n);
        return (exp_in - log2_n) - exp_out;
    endfunction

endpackage

// File: rtl/svreal_if.sv
// Fixed-point real-number bundle: a signed mantissa whose scale is 2**EXPONENT.
interface svreal_if #(
    parameter int WIDTH    = 16,
    parameter int EXPONENT = -8
);
    logic signed [WIDTH-1:0] value;

    modport src (output value);
    modport snk (input value);
endinterface

// File: rtl/real_ring_buf.sv
// Power-of-two ring of signed samples; the slot about to be overwritten is exposed combinationally.
module real_ring_buf #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic signed [WIDTH-1:0] wr_data,
    output logic signed [WIDTH-1:0] oldest
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic signed [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wptr;

    // Read-before-write: the entry leaving the window is visible in the same cycle it is replaced.
    assign oldest = mem[wptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr <= '0;
        end else if (wr_en) begin
            mem[wptr] <= wr_data;
            wptr      <= wptr + 1'b1;
        end
    end

endmodule

// File: rtl/real_moving_avg.sv
// Boxcar mean over the last 2**LOG2_N accepted svreal samples, re-aligned to the output exponent.
module real_moving_avg
    import real_moving_avg_pkg::*;
#(
    parameter int LOG2_N = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    svreal_if.snk           in,
    svreal_if.src           out,
    output logic            out_valid,
    output logic [LOG2_N:0] fill_count
);

    localparam int WIDTH_IN  = in.WIDTH;
    localparam int EXP_IN    = in.EXPONENT;
    localparam int WIDTH_OUT = out.WIDTH;
    localparam int EXP_OUT   = out.EXPONENT;

    localparam int N         = 1 << LOG2_N;
    localparam int AW        = WIDTH_IN + LOG2_N;
    localparam int SHIFT     = calc_shift(EXP_IN, EXP_OUT, LOG2_N);
    localparam int SHIFT_POS = (SHIFT > 0) ? SHIFT : 0;
    localparam int SHIFT_NEG = (SHIFT < 0) ? -SHIFT : 0;
    localparam int EW        = (AW + SHIFT_POS > WIDTH_OUT) ? AW + SHIFT_POS : WIDTH_OUT;

    localparam logic [LOG2_N:0] FULL = (LOG2_N + 1)'(N);

    if (LOG2_N < LOG2_N_MIN || LOG2_N > LOG2_N_MAX) begin : g_bad_log2_n
        $error("real_moving_avg: LOG2_N=%0d outside %0d..%0d", LOG2_N, LOG2_N_MIN, LOG2_N_MAX);
    end

    if (SHIFT > SHIFT_LIMIT || SHIFT < -SHIFT_LIMIT) begin : g_bad_shift
        $error("real_moving_avg: alignment shift %0d exceeds +/-%0d", SHIFT, SHIFT_LIMIT);
    end

    logic signed [WIDTH_IN-1:0]  oldest;
    logic signed [AW-1:0]        acc;
    logic signed [AW-1:0]        acc_next;
    logic [LOG2_N:0]             fill_next;
    logic signed [EW-1:0]        acc_ext;
    logic signed [EW-1:0]        aligned;
    logic signed [WIDTH_OUT-1:0] out_next;
    logic signed [WIDTH_OUT-1:0] out_reg;

    real_ring_buf #(
        .WIDTH      (WIDTH_IN),
        .DEPTH_LOG2 (LOG2_N)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid),
        .wr_data (in.value),
        .oldest  (oldest)
    );

    // The accumulator has LOG2_N guard bits, so the running sum of N samples cannot overflow.
    assign acc_next  = acc + AW'(in.value) - AW'(oldest);
    assign fill_next = (fill_count == FULL) ? fill_count : fill_count + 1'b1;
    assign acc_ext   = EW'(acc_next);

    if (SHIFT >= 0) begin : g_shift_left
        assign aligned = acc_ext <<< SHIFT_POS;
    end else begin : g_shift_right
        assign aligned = acc_ext >>> SHIFT_NEG;
    end

    // Two's-complement wrap into the output width; sizing the output is left to the integrator.
    assign out_next  = WIDTH_OUT'(aligned);
    assign out.value = out_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            fill_count <= '0;
            out_reg    <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                acc        <= acc_next;
                fill_count <= fill_next;
                out_reg    <= out_next;
                out_valid  <= (fill_next == FULL);
            end
        end
    end

endmodule

// File: tb/tb_real_moving_avg.sv
// Scoreboard bench for real_moving_avg: one instance aligns with SHIFT=0, a second with SHIFT=-1.
module tb_real_moving_avg;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_valid;
    logic       out_valid9;
    logic [2:0] fill_count;
    logic [2:0] fill_count9;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int exp9_q[$];
    bit check9 = 1'b0;

    svreal_if #(.WIDTH(16), .EXPONENT(-8))  in_if ();
    svreal_if #(.WIDTH(18), .EXPONENT(-10)) out_if ();
    svreal_if #(.WIDTH(18), .EXPONENT(-9))  out9_if ();

    real_moving_avg #(.LOG2_N(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in         (in_if),
        .out        (out_if),
        .out_valid  (out_valid),
        .fill_count (fill_count)
    );

    real_moving_avg #(.LOG2_N(2)) dut9 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in         (in_if),
        .out        (out9_if),
        .out_valid  (out_valid9),
        .fill_count (fill_count9)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Drives one cycle of input; when an output pulse is due, its expected mean is queued.
    task automatic applyStimulus(input int v, input bit valid, input bit push, input int e,
                                 input bit push9, input int e9);
        in_if.value = 16'(v);
        in_valid = valid;
        if (push) exp_q.push_back(e);
        if (push9) exp9_q.push_back(e9);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drainQueues(input string name);
        for (int i = 0; i < 6 && (exp_q.size() != 0 || exp9_q.size() != 0); i++) begin
            @(negedge clk);
            #1;
        end
        checkOutput({name, "_drain"}, exp_q.size() + exp9_q.size(), 0);
    endtask

    initial begin
        in_if.value = '0;

        fork
            forever begin
                @(negedge clk);
                if (out_valid) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("[TB] FAIL unexpected_valid: out_valid with out.value=%0d, expected no pulse",
                                 int'(out_if.value));
                    end else begin
                        int e;
                        e = exp_q.pop_front();
                        if (int'(out_if.value) != e) begin
                            failures++;
                            $display("[TB] FAIL mean: got %0d, expected %0d", int'(out_if.value), e);
                        end
                    end
                end
                if (check9 && out_valid9) begin
                    checks++;
                    if (exp9_q.size() == 0) begin
                        failures++;
                        $display("[TB] FAIL unexpected_valid9: out_valid with out.value=%0d, expected no pulse",
                                 int'(out9_if.value));
                    end else begin
                        int e;
                        e = exp9_q.pop_front();
                        if (int'(out9_if.value) != e) begin
                            failures++;
                            $display("[TB] FAIL mean9: got %0d, expected %0d", int'(out9_if.value), e);
                        end
                    end
                end
            end
        join_none

        // Scenario 1: 1.0, 2.0, 3.0, 4.0 -> 2.5
        doReset();
        checkOutput("reset_value", int'(out_if.value), 0);
        checkOutput("reset_valid", int'(out_valid), 0);
        checkOutput("reset_fill", int'(fill_count), 0);
        applyStimulus(256, 1, 0, 0, 0, 0);
        checkOutput("s1_fill1", int'(fill_count), 1);
        applyStimulus(512, 1, 0, 0, 0, 0);
        applyStimulus(768, 1, 0, 0, 0, 0);
        checkOutput("s1_partial_value", int'(out_if.value), 1536);
        checkOutput("s1_partial_valid", int'(out_valid), 0);
        applyStimulus(1024, 1, 1, 2560, 0, 0);
        checkOutput("s1_latency_valid", int'(out_valid), 1);
        checkOutput("s1_fill4", int'(fill_count), 4);

        // Scenario 2: 5.0 -> 3.5, then idle holds the value
        applyStimulus(1280, 1, 1, 3584, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkOutput("s2_idle_value", int'(out_if.value), 3584);
            checkOutput("s2_idle_valid", int'(out_valid), 0);
        end
        drainQueues("s2");

        // Scenario 3: single LSB, exact at EXP -10, floored at EXP -9
        doReset();
        check9 = 1'b1;
        applyStimulus(1, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 1, 1, 0);
        checkOutput("s3_fill9", int'(fill_count9), 4);
        drainQueues("s3a");
        doReset();
        applyStimulus(-1, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, -1, 1, -1);
        drainQueues("s3b");
        check9 = 1'b0;

        // Scenario 4: constant -1.0 saturates the fill counter
        doReset();
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(-256, 1, (k >= 4), -1024, 0, 0);
        end
        checkOutput("s4_fill_sat", int'(fill_count), 4);
        drainQueues("s4");

        // Scenario 5: reset mid-window with in_valid high drops the presented sample
        doReset();
        applyStimulus(768, 1, 0, 0, 0, 0);
        applyStimulus(768, 1, 0, 0, 0, 0);
        in_if.value = 16'(768);
        in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        checkOutput("s5_reset_value", int'(out_if.value), 0);
        checkOutput("s5_reset_valid", int'(out_valid), 0);
        checkOutput("s5_reset_fill", int'(fill_count), 0);
        applyStimulus(256, 1, 0, 0, 0, 0);
        applyStimulus(256, 1, 0, 0, 0, 0);
        applyStimulus(256, 1, 0, 0, 0, 0);
        checkOutput("s5_partial_value", int'(out_if.value), 768);
        applyStimulus(256, 1, 1, 1024, 0, 0);
        drainQueues("s5");

        // Scenario 6: 1.0..12.0 across several pointer wraps; mean is (k-1.5)*1024
        doReset();
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(k * 256, 1, (k >= 4), (4 * k - 6) * 256, 0, 0);
        end
        drainQueues("s6");
        checkOutput("s6_final_value", int'(out_if.value), 10752);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
